// File: rtl/width_arbiter_pkg.sv
// rtl/width_arbiter_pkg.sv - shared FSM state type and parameter defaults for width_arbiter
package width_arbiter_pkg;

  // EMPTY: no word held; FULL: output register holds a word (out_valid=1)
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam int NUM_REQ_DEFAULT   = 4;
  localparam int SIZE_IN_DEFAULT   = 32;
  localparam int MAX_BURST_DEFAULT = 4;

endpackage

// File: rtl/width_arbiter_rr_arbiter.sv
// rtl/width_arbiter_rr_arbiter.sv - rotating-priority search: first request at or after start wins
module rr_arbiter
  import width_arbiter_pkg::*;
#(
  parameter int N = NUM_REQ_DEFAULT,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o
);

  logic [IW:0]   sum;
  logic [IW-1:0] cur;
  logic          found;

  // Walk the request vector from start_i with wrap; the first set bit is the one-hot winner
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    sum         = '0;
    cur         = '0;
    for (int off = 0; off < N; off++) begin
      sum = {1'b0, start_i} + (IW+1)'(off);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      cur = sum[IW-1:0];
      if (!found && req_i[cur]) begin
        found        = 1'b1;
        grant_o[cur] = 1'b1;
        grant_idx_o  = cur;
      end
    end
  end

endmodule

// File: rtl/width_arbiter.sv
// rtl/width_arbiter.sv - round-robin N:1 word arbiter with one-word output register; burst option WIDTH_ARBITER_BURST_EN
module width_arbiter
  import width_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEFAULT,
  parameter int SIZE_IN   = SIZE_IN_DEFAULT,
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*SIZE_IN-1:0] req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  output logic [SIZE_IN-1:0]         out_data,
  output logic [$clog2(NUM_REQ)-1:0] out_id,
  input  logic                       out_ready
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

  state_e              state_q, state_d;
  logic [SIZE_IN-1:0]  data_q, data_d;
  logic [IW-1:0]       id_q, id_d;
  logic [IW-1:0]       last_q, last_d;

  logic [IW-1:0]       next_ptr;
  logic [IW-1:0]       start;
  logic [NUM_REQ-1:0]  grant;
  logic [IW-1:0]       grant_idx;
  logic                can_load;
  logic                xfer;

  assign next_ptr = (last_q == LAST_IDX) ? '0 : last_q + 1'b1;

`ifdef WIDTH_ARBITER_BURST_EN
  localparam int BW = $clog2(MAX_BURST + 1);

  logic [BW-1:0] burst_q, burst_d;
  logic          hold;

  // Stay on the previous winner while it keeps requesting and its run is not yet MAX_BURST long;
  // a zero count means no run in progress, so reset state does not favour the last index
  assign hold  = req_valid[last_q] && (burst_q != '0) && (burst_q < BW'(MAX_BURST));
  assign start = hold ? last_q : next_ptr;

  // Count consecutive words to the same requester; any fresh round-robin win starts a new run
  always_comb begin
    burst_d = burst_q;
    if (xfer) begin
      burst_d = hold ? burst_q + 1'b1 : BW'(1);
    end
  end

  // Burst counter register
  always_ff @(posedge clk) begin
    if (!reset) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end
`else
  assign start = next_ptr;
`endif

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr (
    .req_i      (req_valid),
    .start_i    (start),
    .grant_o    (grant),
    .grant_idx_o(grant_idx)
  );

  // A new word may enter when the register is empty or being drained this cycle
  assign can_load  = reset && ((state_q == ST_EMPTY) || out_ready);
  assign req_ready = can_load ? grant : '0;
  assign xfer      = |req_ready;

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_id    = id_q;

  // Next-state: load on transfer, drain to EMPTY when consumed with nothing to replace it
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    last_d  = last_q;
    case (state_q)
      ST_EMPTY: if (xfer) state_d = ST_FULL;
      ST_FULL:  if (out_ready && !xfer) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (xfer) begin
      data_d = req_data[grant_idx*SIZE_IN +: SIZE_IN];
      id_d   = grant_idx;
      last_d = grant_idx;
    end
  end

  // State, output word and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      last_q  <= LAST_IDX;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_width_arbiter.sv
// tb/tb_width_arbiter.sv - directed and random self-checking bench for width_arbiter
module tb_width_arbiter;

  localparam int NR = 4;
  localparam int SW = 32;
  localparam int MB = 4;

  logic              clk;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*SW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              out_valid;
  logic [SW-1:0]     out_data;
  logic [1:0]        out_id;
  logic              out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  width_arbiter #(
    .NUM_REQ  (NR),
    .SIZE_IN  (SW),
    .MAX_BURST(MB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_id   (out_id),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_word(input int k, input logic [31:0] w);
    req_data[k*SW +: SW] = w;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset     = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    req_data  = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < NR; k++) set_word(k, 32'hAAAA_0000 | k);
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_req_ready actual=%b expected=%b", req_ready, 4'b0000);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid actual=%b expected=0", out_valid);
    end
    n_checks++;
    if (out_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_out_data actual=%h expected=0", out_data);
    end
    n_checks++;
    if (out_id !== 2'd0) begin
      n_fail++; $display("FAIL reset_out_id actual=%0d expected=0", out_id);
    end
  endtask

  task automatic test_round_robin();
    int exp_ids[9];
`ifdef WIDTH_ARBITER_BURST_EN
    exp_ids = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
`else
    exp_ids = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
`endif
    apply_reset();
    for (int k = 0; k < NR; k++) set_word(k, 32'hC0DE_0000 | k);
    req_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL rr_first_ready actual=%b expected=0001", req_ready);
    end
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_id !== 2'(exp_ids[i]) ||
          out_data !== (32'hC0DE_0000 | exp_ids[i])) begin
        n_fail++;
        $display("FAIL rr_seq[%0d] actual valid=%b id=%0d data=%h expected valid=1 id=%0d data=%h",
                 i, out_valid, out_id, out_data, exp_ids[i], 32'hC0DE_0000 | exp_ids[i]);
      end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    set_word(2, 32'hDEAD_BEEF);
    req_valid = 4'b0100;
    out_ready = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL stall_load_ready actual=%b expected=0100", req_ready);
    end
    @(negedge clk);
    set_word(0, 32'h0000_0000);
    set_word(1, 32'h1111_1111);
    set_word(2, 32'h1234_5678);
    set_word(3, 32'h3333_3333);
    req_valid = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF || out_id !== 2'd2 || req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] actual valid=%b data=%h id=%0d ready=%b expected valid=1 data=deadbeef id=2 ready=0000",
                 i, out_valid, out_data, out_id, req_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL stall_resume_ready actual=%b expected=1000", req_ready);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd3 || out_data !== 32'h3333_3333) begin
      n_fail++;
      $display("FAIL stall_resume_word actual valid=%b id=%0d data=%h expected valid=1 id=3 data=33333333",
               out_valid, out_id, out_data);
    end
  endtask

  task automatic test_single_pulse();
    apply_reset();
    out_ready = 1'b1;
    set_word(0, 32'hBAD0_0000);
    set_word(1, 32'hBAD1_0000);
    set_word(3, 32'hBAD3_0000);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        set_word(2, 32'h2000_0000 + i / 2);
        req_valid = 4'b0100;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || req_ready !== 4'b0100) begin
          n_fail++;
          $display("FAIL pulse_load[%0d] actual valid=%b ready=%b expected valid=0 ready=0100", i, out_valid, req_ready);
        end
      end else begin
        req_valid = 4'b0000;
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd2 || out_data !== (32'h2000_0000 + i / 2) || req_ready !== 4'b0000) begin
          n_fail++;
          $display("FAIL pulse_word[%0d] actual valid=%b id=%0d data=%h expected valid=1 id=2 data=%h",
                   i, out_valid, out_id, out_data, 32'h2000_0000 + i / 2);
        end
      end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL pulse_drained actual valid=%b expected=0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int k = 0; k < NR; k++) set_word(k, 32'h5A5A_0000 | k);
    req_valid = 4'b1111;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_ready_comb actual=%b expected=0000", req_ready);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || req_ready !== 4'b0000 || out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_cleared actual valid=%b ready=%b data=%h expected valid=0 ready=0000 data=0",
               out_valid, req_ready, out_data);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL rstmid_first_ready actual=%b expected=0001", req_ready);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== 32'h5A5A_0000) begin
      n_fail++;
      $display("FAIL rstmid_first_word actual valid=%b id=%0d data=%h expected valid=1 id=0 data=5a5a0000",
               out_valid, out_id, out_data);
    end
  endtask

  task automatic test_random();
    int          seq[NR];
    int          wait_cnt[NR];
    logic [31:0] exp_q[$];
    int          exp_id_q[$];
    logic        model_full;
    logic        exp_any;
    int          acc;
    int          pending;
    apply_reset();
    model_full = 1'b0;
    pending    = -1;
    for (int k = 0; k < NR; k++) begin
      seq[k]      = 0;
      wait_cnt[k] = 0;
      set_word(k, {4'(k), 28'(seq[k])});
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (pending >= 0) begin
        seq[pending]++;
        set_word(pending, {4'(pending), 28'(seq[pending])});
      end
      req_valid = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_checks++;
      if (out_valid !== model_full) begin
        n_fail++; $display("FAIL rand_out_valid cyc=%0d actual=%b expected=%b", cyc, out_valid, model_full);
      end
      if (model_full && out_ready && exp_q.size() > 0) begin
        n_checks++;
        if (out_data !== exp_q[0] || out_id !== 2'(exp_id_q[0])) begin
          n_fail++;
          $display("FAIL rand_order cyc=%0d actual id=%0d data=%h expected id=%0d data=%h",
                   cyc, out_id, out_data, exp_id_q[0], exp_q[0]);
        end
        void'(exp_q.pop_front());
        void'(exp_id_q.pop_front());
      end
      n_checks++;
      if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != 4'b0000) begin
        n_fail++; $display("FAIL rand_onehot cyc=%0d actual ready=%b valid=%b", cyc, req_ready, req_valid);
      end
      exp_any = (|req_valid) && (!model_full || out_ready);
      n_checks++;
      if ((|req_ready) !== exp_any) begin
        n_fail++; $display("FAIL rand_accept cyc=%0d actual=%b expected=%b", cyc, |req_ready, exp_any);
      end
      pending = -1;
      if (|req_ready) begin
        acc = 0;
        for (int j = 0; j < NR; j++) if (req_ready[j]) acc = j;
        pending = acc;
        exp_q.push_back({4'(acc), 28'(seq[acc])});
        exp_id_q.push_back(acc);
        for (int j = 0; j < NR; j++) begin
          if (j == acc || !req_valid[j]) begin
            wait_cnt[j] = 0;
          end else begin
            wait_cnt[j]++;
            n_checks++;
            if (wait_cnt[j] > NR * MB) begin
              n_fail++;
              $display("FAIL rand_starve cyc=%0d req=%0d actual wait=%0d limit=%0d", cyc, j, wait_cnt[j], NR * MB);
            end
          end
        end
        model_full = 1'b1;
      end else begin
        for (int j = 0; j < NR; j++) if (!req_valid[j]) wait_cnt[j] = 0;
        if (out_ready) model_full = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_stall();
    test_single_pulse();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
